lsu_mem_stage: RTL

//  Memory-access stage directly downstream of the 12-bit address ALU. Latches the computed

---
 rtl/lsu_mem_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: latches an issued load/store, runs one word access on the
// data-memory port with a ready handshake and timeout, and returns load write-back.
//
// state  | meaning
// IDLE   | waiting for an issued load/store
// ACCESS | dm_cs asserted, waiting for dm_ready or timeout
// DONE   | one cycle: write-back pulse for loads
// ERR    | one cycle: misalign or mem_timeout pulse
module lsu_mem_stage #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_mem,
    input  logic [5:0]        opcode,
    input  logic [7:0]        sub_opcode_8bit,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rd_index,
    output logic              dm_cs,
    output logic              dm_we,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ready,
    output logic              busy,
    output logic [DATA_W-1:0] load_data,
    output logic              wb_enable,
    output logic [4:0]        wb_index,
    output logic              misalign,
    output logic              mem_timeout
);

    localparam logic [5:0] OP_LWI     = 6'b000010;
    localparam logic [5:0] OP_SWI     = 6'b001010;
    localparam logic [5:0] OP_TYPE_LS = 6'b011100;
    localparam logic [7:0] SUB_LW     = 8'b00000010;
    localparam logic [7:0] SUB_SW     = 8'b00001010;
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t            state, state_n;
    logic [7:0]        cnt;
    logic [ADDR_W-3:0] word_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        rd_q;
    logic              load_q;
    logic              misalign_q;
    logic              is_load, is_store, accept;

    assign is_load  = (opcode == OP_LWI) ||
                      ((opcode == OP_TYPE_LS) && (sub_opcode_8bit == SUB_LW));
    assign is_store = (opcode == OP_SWI) ||
                      ((opcode == OP_TYPE_LS) && (sub_opcode_8bit == SUB_SW));
    assign accept   = (state == IDLE) && enable_mem && (is_load || is_store);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            word_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            load_q     <= 1'b0;
            misalign_q <= 1'b0;
            load_data  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                word_q     <= mem_addr[ADDR_W-1:2];
                wdata_q    <= store_data;
                rd_q       <= rd_index;
                load_q     <= is_load;
                misalign_q <= (mem_addr[1:0] != 2'b00);
                cnt        <= '0;
            end else if (state == ACCESS) begin
                if (dm_ready) begin
                    if (load_q)
                        load_data <= dm_rdata;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (mem_addr[1:0] != 2'b00) ? ERR : ACCESS;
            ACCESS: begin
                if (dm_ready)
                    state_n = DONE;
                else if (cnt == CNT_LAST)
                    state_n = ERR;
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address/data come straight from the latches so they are stable for the whole access.
    assign busy        = (state != IDLE);
    assign dm_cs       = (state == ACCESS);
    assign dm_we       = (state == ACCESS) && !load_q;
    assign dm_addr     = word_q;
    assign dm_wdata    = wdata_q;
    assign wb_enable   = (state == DONE) && load_q;
    assign wb_index    = ((state == DONE) && load_q) ? rd_q : 5'd0;
    assign misalign    = (state == ERR) && misalign_q;
    assign mem_timeout = (state == ERR) && !misalign_q;

endmodule
